// File: rtl/spec_avg_pkg.sv
// Shared types and parameter limits for the spec_avg spectral averager.
package spec_avg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int LGFFT_MIN = 2;
    localparam int LGFFT_MAX = 12;
    localparam int DW_MIN    = 1;
    localparam int DW_MAX    = 16;
    localparam int LGAVG_MIN = 1;
    localparam int LGAVG_MAX = 6;

    // Accumulator width: headroom for sample<<LGAVG.
    function automatic int aw_of(input int dw, input int lgavg);
        return dw + lgavg;
    endfunction

endpackage

// File: rtl/spec_avg_ram.sv
// Simple dual-port RAM: one write port, one registered read port. Contents are not reset.
module spec_avg_ram #(
    parameter int W       = 8,
    parameter int LGDEPTH = 4
) (
    input  logic               i_clk,
    input  logic               we,
    input  logic [LGDEPTH-1:0] waddr,
    input  logic [W-1:0]       wdata,
    input  logic               re,
    input  logic [LGDEPTH-1:0] raddr,
    output logic [W-1:0]       rdata
);
    logic [W-1:0] mem [0:(1<<LGDEPTH)-1];

    always_ff @(posedge i_clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/spec_avg.sv
// Per-bin recursive spectral averager (read-modify-write over a bin RAM).
// Optional per-bin peak hold: define SPEC_AVG_PEAKHOLD_EN.
module spec_avg
    import spec_avg_pkg::*;
#(
    parameter int LGFFT = 10,
    parameter int DW    = 8,
    parameter int LGAVG = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_sync,
    input  logic [DW-1:0] i_sample,
    input  logic          i_clear,
    output logic [DW-1:0] o_sample,
    output logic          o_sync,
    output logic          o_err
`ifdef SPEC_AVG_PEAKHOLD_EN
    ,
    output logic [DW-1:0] o_peak
`endif
);
    localparam int AW     = aw_of(DW, LGAVG);
    localparam int STAGES = 1;

    if (LGFFT < LGFFT_MIN || LGFFT > LGFFT_MAX || DW < DW_MIN || DW > DW_MAX ||
        LGAVG < LGAVG_MIN || LGAVG > LGAVG_MAX) begin : g_bad_param
        $error("spec_avg: LGFFT, DW or LGAVG out of range");
    end

    typedef struct packed {
        logic [LGFFT-1:0] addr;
        logic [DW-1:0]    sample;
        logic             sync;
        logic             err;
        logic             prime;
    } stg_t;

    state_t           state, state_nx;
    logic [LGFFT-1:0] cnt, bin;
    logic             clr_pend, clr_now, consume, cnt_full, fstart;
    logic             in_vld, in_prime, in_err;
    logic [STAGES:0]  vld_pipe;
    stg_t             s0, s1;
    logic             we, fwd_hit, fwd_q;
    logic [AW-1:0]    acc_rd, acc_old, acc_new, fwd_acc;

    always_comb begin
        cnt_full = &cnt;
        fstart   = i_sync || cnt_full;
        clr_now  = clr_pend || i_clear;
        bin      = i_sync ? '0 : cnt + LGFFT'(1);
        state_nx = state;
        consume  = 1'b0;
        in_err   = 1'b0;
        case (state)
            IDLE: begin
                if (i_sync) begin
                    state_nx = PRIME;
                    consume  = 1'b1;
                end
            end
            default: begin
                // A wrap without sync is still a frame start, just a flagged one.
                if (fstart) begin
                    state_nx = clr_now ? PRIME : RUN;
                    consume  = 1'b1;
                end
                in_err = i_sync != cnt_full;
            end
        endcase
        in_vld   = state_nx != IDLE;
        in_prime = state_nx == PRIME;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_pend <= 1'b0;
            vld_pipe <= '0;
            fwd_q    <= 1'b0;
        end else if (i_ce) begin
            state    <= state_nx;
            cnt      <= bin;
            clr_pend <= clr_now && !consume;
            vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};
            fwd_q    <= fwd_hit;
        end else if (i_clear) begin
            clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            s0      <= '{addr: bin, sample: i_sample, sync: fstart, err: in_err, prime: in_prime};
            s1      <= s0;
            fwd_acc <= acc_new;
        end
    end

    // Back-to-back hits on one bin (sync right after sync) read before the write lands.
    assign we      = i_ce && vld_pipe[1];
    assign fwd_hit = vld_pipe[1] && vld_pipe[0] && (s1.addr == s0.addr);

    always_comb begin
        acc_old = fwd_q ? fwd_acc : acc_rd;
        if (s1.prime)
            acc_new = {s1.sample, {LGAVG{1'b0}}};
        else
            acc_new = acc_old - (acc_old >> LGAVG) + AW'(s1.sample);
    end

    spec_avg_ram #(.W(AW), .LGDEPTH(LGFFT)) u_acc_ram (
        .i_clk (i_clk),
        .we    (we),
        .waddr (s1.addr),
        .wdata (acc_new),
        .re    (i_ce),
        .raddr (s0.addr),
        .rdata (acc_rd)
    );

`ifdef SPEC_AVG_PEAKHOLD_EN
    logic [DW-1:0] pk_rd, pk_old, pk_new, fwd_pk;

    always_comb begin
        pk_old = fwd_q ? fwd_pk : pk_rd;
        if (s1.prime || s1.sample > pk_old)
            pk_new = s1.sample;
        else
            pk_new = pk_old;
    end

    always_ff @(posedge i_clk) begin
        if (i_ce)
            fwd_pk <= pk_new;
    end

    spec_avg_ram #(.W(DW), .LGDEPTH(LGFFT)) u_peak_ram (
        .i_clk (i_clk),
        .we    (we),
        .waddr (s1.addr),
        .wdata (pk_new),
        .re    (i_ce),
        .raddr (s0.addr),
        .rdata (pk_rd)
    );
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sample <= '0;
            o_sync   <= 1'b0;
            o_err    <= 1'b0;
`ifdef SPEC_AVG_PEAKHOLD_EN
            o_peak   <= '0;
`endif
        end else if (i_ce) begin
            o_sample <= vld_pipe[1] ? (s1.prime ? s1.sample : acc_new[AW-1:LGAVG]) : '0;
            o_sync   <= vld_pipe[1] && s1.sync;
            o_err    <= vld_pipe[1] && s1.err;
`ifdef SPEC_AVG_PEAKHOLD_EN
            o_peak   <= vld_pipe[1] ? pk_new : '0;
`endif
        end
    end

endmodule

// File: tb/tb_spec_avg.sv
// Self-checking bench for spec_avg (LGFFT=4, LGAVG=2) against a per-bin arithmetic model.
module tb_spec_avg;
    localparam int LGFFT = 4;
    localparam int DW    = 8;
    localparam int LGAVG = 2;
    localparam int NB    = 16;

    logic          i_clk = 1'b0, i_reset_n = 1'b0, i_ce = 1'b0, i_sync = 1'b0, i_clear = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic [DW-1:0] o_sample;
    logic          o_sync, o_err;
`ifdef SPEC_AVG_PEAKHOLD_EN
    logic [DW-1:0] o_peak;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] s;
        logic       sy;
        logic       er;
        logic [7:0] pk;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   m_acc[NB];
    int   m_pk[NB];
    int   m_bin;
    bit   m_active, m_prime, m_clr;

    spec_avg #(.LGFFT(LGFFT), .DW(DW), .LGAVG(LGAVG)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_sync    (i_sync),
        .i_sample  (i_sample),
        .i_clear   (i_clear),
        .o_sample  (o_sample),
        .o_sync    (o_sync),
        .o_err     (o_err)
`ifdef SPEC_AVG_PEAKHOLD_EN
        ,
        .o_peak    (o_peak)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{s: 8'h00, sy: 1'b0, er: 1'b0, pk: 8'h00, tag: -1};
        return e;
    endfunction

    // Frame-level model: decides frame mode at frame starts, then does the average arithmetic.
    function automatic exp_t model(input bit sync, input int smp, input bit clr, input int tag);
        exp_t e;
        bit   last, fs;
        e    = zero_exp();
        last = (m_bin == NB - 1);
        fs   = sync || last;
        m_clr = m_clr || clr;
        if (!m_active) begin
            if (sync) begin
                m_active = 1'b1;
                m_prime  = 1'b1;
                m_clr    = 1'b0;
            end
        end else begin
            e.er = (sync != last);
            if (fs) begin
                m_prime = m_clr;
                m_clr   = 1'b0;
            end
        end
        m_bin = sync ? 0 : (m_bin + 1) % NB;
        if (m_active) begin
            if (m_prime) begin
                m_acc[m_bin] = smp * 4;
                m_pk[m_bin]  = smp;
            end else begin
                m_acc[m_bin] = m_acc[m_bin] - m_acc[m_bin] / 4 + smp;
                if (smp > m_pk[m_bin]) m_pk[m_bin] = smp;
            end
            e.s   = m_prime ? 8'(smp) : 8'(m_acc[m_bin] / 4);
            e.pk  = 8'(m_pk[m_bin]);
            e.sy  = fs;
            e.tag = tag;
        end
        return e;
    endfunction

    task automatic reset_model();
        m_active = 1'b0;
        m_prime  = 1'b0;
        m_clr    = 1'b0;
        m_bin    = 0;
        exp_q.delete();
        exp_q.push_back(zero_exp());
        exp_q.push_back(zero_exp());
        cur = zero_exp();
    endtask

    // Drives one clock; on an accepted sample the expectation queue advances by one.
    task automatic step(input bit ce, input bit sync, input int smp, input bit clr, input int tag);
        @(negedge i_clk);
        i_ce     = ce;
        i_sync   = sync;
        i_sample = DW'(smp);
        i_clear  = clr;
        @(posedge i_clk);
        #1;
        if (ce) begin
            exp_q.push_back(model(sync, smp, clr, tag));
            cur = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        reset_model();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_sample, o_sync, o_err} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", o_sample, o_sync, o_err);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_constant();
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < NB; b++) begin
                step(1'b1, b == 0, 8'h80, 1'b0, 100 + f);
                checks++;
                if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                    errors++;
                    $display("FAIL const_model got=%h/%b/%b exp=%h/%b/%b", o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
                end
                if (cur.tag >= 100) begin
                    checks++;
                    if (o_sample !== 8'h80) begin
                        errors++;
                        $display("FAIL const_value got=%h exp=80", o_sample);
                    end
                end
            end
    endtask

    task automatic test_step();
        int want[4];
        want = '{0, 63, 111, 147};
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < NB; b++) begin
                step(1'b1, b == 0, (f == 0) ? 8'h00 : 8'hFF, (f == 0 && b == 0), 200 + f);
                checks++;
                if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                    errors++;
                    $display("FAIL step_model got=%h/%b/%b exp=%h/%b/%b", o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
                end
                if (cur.tag >= 200 && cur.tag <= 203) begin
                    checks++;
                    if (o_sample !== 8'(want[cur.tag - 200])) begin
                        errors++;
                        $display("FAIL step_value frame=%0d got=%0d exp=%0d", cur.tag - 200, o_sample, want[cur.tag - 200]);
                    end
                end
            end
    endtask

    // Short frame at bin 9, sync-after-sync (forwarding), then a missing sync (wrap).
    task automatic test_short_frame();
        bit sy[$];
        int tg[$];
        for (int b = 0; b < NB; b++) begin sy.push_back(b == 0); tg.push_back(300); end
        for (int b = 0; b < 9; b++)  begin sy.push_back(b == 0); tg.push_back(300); end
        sy.push_back(1'b1); tg.push_back(301);
        sy.push_back(1'b1); tg.push_back(302);
        for (int b = 1; b < NB; b++) begin sy.push_back(1'b0); tg.push_back(300); end
        for (int b = 0; b < NB; b++) begin sy.push_back(b == 0); tg.push_back(300); end
        sy.push_back(1'b0); tg.push_back(303);
        for (int b = 1; b < NB; b++) begin sy.push_back(1'b0); tg.push_back(300); end
        for (int b = 0; b < NB; b++) begin sy.push_back(b == 0); tg.push_back(300); end
        for (int i = 0; i < sy.size(); i++) begin
            step(1'b1, sy[i], int'($urandom_range(0, 255)), 1'b0, tg[i]);
            checks++;
            if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                errors++;
                $display("FAIL short_model i=%0d got=%h/%b/%b exp=%h/%b/%b", i, o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
            end
            if (cur.tag >= 301 && cur.tag <= 303) begin
                checks++;
                if (o_err !== 1'b1) begin
                    errors++;
                    $display("FAIL short_err case=%0d got=%b exp=1", cur.tag - 300, o_err);
                end
            end
        end
    endtask

    task automatic test_clear();
        for (int f = 0; f < 5; f++)
            for (int b = 0; b < NB; b++) begin
                step(1'b1, b == 0, (f < 3) ? 8'h10 : 8'hF0, (f == 0 && b == 0) || (f == 2 && b == 5), 400 + f);
                checks++;
                if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                    errors++;
                    $display("FAIL clear_model got=%h/%b/%b exp=%h/%b/%b", o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
                end
                if (cur.tag >= 401) begin
                    checks++;
                    if (o_sample !== ((cur.tag >= 403) ? 8'hF0 : 8'h10)) begin
                        errors++;
                        $display("FAIL clear_value frame=%0d got=%h", cur.tag - 400, o_sample);
                    end
                end
            end
    endtask

    task automatic test_reset_mid();
        int psmp[NB];
        for (int b = 0; b < 8; b++) step(1'b1, b == 0, int'($urandom_range(0, 255)), 1'b0, 500);
        #2;
        i_reset_n = 1'b0;
        reset_model();
        #1;
        checks++;
        if ({o_sample, o_sync, o_err} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_immediate got=%h/%b/%b exp=00/0/0", o_sample, o_sync, o_err);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, int'($urandom_range(1, 255)), 1'b0, 500);
            checks++;
            if ({o_sample, o_sync, o_err} !== {8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL midreset_idle got=%h/%b/%b exp=00/0/0", o_sample, o_sync, o_err);
            end
        end
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < NB; b++) begin
                int smp;
                smp = int'($urandom_range(0, 255));
                if (f == 0) psmp[b] = smp;
                step(1'b1, b == 0, smp, 1'b0, (f == 0) ? 510 + b : 500);
                checks++;
                if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                    errors++;
                    $display("FAIL midreset_model got=%h/%b/%b exp=%h/%b/%b", o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
                end
                if (cur.tag >= 510) begin
                    checks++;
                    if (o_sample !== 8'(psmp[cur.tag - 510])) begin
                        errors++;
                        $display("FAIL midreset_prime bin=%0d got=%h exp=%h", cur.tag - 510, o_sample, psmp[cur.tag - 510]);
                    end
                end
            end
    endtask

    // Sparse strobes: outputs must hold between i_ce and RAM data in flight must survive.
    task automatic test_sparse();
        int acc_n;
        acc_n = 0;
        while (acc_n < 3 * NB) begin
            bit ce;
            ce = ($urandom_range(0, 2) != 0);
            step(ce, ce && (acc_n % NB == 0), int'($urandom_range(0, 255)), 1'b0, 600);
            if (ce) acc_n++;
            checks++;
            if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                errors++;
                $display("FAIL sparse_model ce=%b got=%h/%b/%b exp=%h/%b/%b", ce, o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pos;
        pos = 0;
        for (int i = 0; i < 6 * NB; i++) begin
            bit sync;
            sync = (pos % NB == 0) || ($urandom_range(0, 39) == 0);
            if (sync) pos = 0;
            pos++;
            step(1'b1, sync, int'($urandom_range(0, 255)), $urandom_range(0, 19) == 0, 650);
            checks++;
            if ({o_sample, o_sync, o_err} !== {cur.s, cur.sy, cur.er}) begin
                errors++;
                $display("FAIL b2b_model i=%0d got=%h/%b/%b exp=%h/%b/%b", i, o_sample, o_sync, o_err, cur.s, cur.sy, cur.er);
            end
        end
    endtask

`ifdef SPEC_AVG_PEAKHOLD_EN
    task automatic test_peak();
        int b3[3];
        int want[3];
        b3   = '{8'h20, 8'h90, 8'h40};
        want = '{8'h20, 8'h90, 8'h90};
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < NB; b++) begin
                int smp;
                smp = (b == 3 && f < 3) ? b3[f] : int'($urandom_range(0, 255));
                step(1'b1, b == 0, smp, (f == 0 && b == 0), (b == 3 && f < 3) ? 700 + f : 799);
                checks++;
                if ({o_sample, o_sync, o_err, o_peak} !== {cur.s, cur.sy, cur.er, cur.pk}) begin
                    errors++;
                    $display("FAIL peak_model got=%h/%b/%b/%h exp=%h/%b/%b/%h", o_sample, o_sync, o_err, o_peak, cur.s, cur.sy, cur.er, cur.pk);
                end
                if (cur.tag >= 700 && cur.tag <= 702) begin
                    checks++;
                    if (o_peak !== 8'(want[cur.tag - 700])) begin
                        errors++;
                        $display("FAIL peak_bin3 frame=%0d got=%h exp=%h", cur.tag - 700, o_peak, want[cur.tag - 700]);
                    end
                end
            end
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_step();
        test_short_frame();
        test_clear();
        test_reset_mid();
        test_sparse();
        test_back_to_back();
`ifdef SPEC_AVG_PEAKHOLD_EN
        test_peak();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
